// File: rtl/period_meter.sv
// period_meter
// ------------
// Measures a slow square wave (typically the divided project clock) against
// the system clock. One measurement reports, in clock_in cycles:
//   period_out : rising edge to next rising edge
//   high_out   : rising edge to the falling edge that follows it
// The result is presented with a valid/ack handshake. A stuck input aborts
// the measurement after TIMEOUT cycles and raises the sticky timeout flag.
//
// Ports:
//   clock_in   - system clock, all logic on the rising edge
//   reset_n    - asynchronous active-low reset
//   sig_in     - signal under measurement, asynchronous to clock_in
//   start      - one-cycle request to begin a measurement (honoured in IDLE/DONE)
//   ack        - consumer acknowledges the presented result
//   busy       - high while waiting for the first edge or measuring
//   valid      - result available on period_out/high_out
//   timeout    - sticky, last measurement aborted for lack of an edge
//   period_out - measured period in cycles
//   high_out   - measured high time in cycles
//
// Build option:
//   PERIOD_METER_CONTINUOUS_EN - when defined, every terminating rising edge
//   also starts the next measurement; valid becomes a one-cycle pulse per
//   completed period and ack is ignored. Undefined gives single-shot operation.

module period_meter #(
  parameter int unsigned          CNT_WIDTH = 28,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = 28'd50000000
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 ack,
  output logic                 busy,
  output logic                 valid,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic [CNT_WIDTH-1:0] high_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ABORT  = TIMEOUT - CNT_ONE;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] high_cnt;
  logic                 fall_seen;
  logic                 sync1;
  logic                 sync2;
  logic                 sync3;
  logic                 rise;
  logic                 fall;
  logic                 cnt_at_limit;

  // Two-flop synchronizer followed by an edge register. Every edge passes
  // through the same three flops, so the fixed latency cancels out of the
  // measured intervals.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise         = sync2 & ~sync3;
  assign fall         = ~sync2 & sync3;
  assign cnt_inc      = cnt + CNT_ONE;
  assign cnt_at_limit = (cnt == CNT_ABORT);

  // Measurement sequencer. The high time is captured into high_cnt and only
  // copied to high_out when the period completes, so an aborted measurement
  // leaves both result registers exactly as the last good measurement left
  // them. A rise with no fall in between is reported as 100% high.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= CNT_ZERO;
      high_cnt   <= CNT_ZERO;
      fall_seen  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      period_out <= CNT_ZERO;
      high_out   <= CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            cnt     <= CNT_ZERO;
            timeout <= 1'b0;
            busy    <= 1'b1;
          end
        end

        ARM: begin
          if (rise) begin
            state     <= MEASURE;
            cnt       <= CNT_ZERO;
            fall_seen <= 1'b0;
          end else if (cnt_at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end

        MEASURE: begin
          valid <= 1'b0;
          if (rise) begin
            period_out <= cnt_inc;
            high_out   <= fall_seen ? high_cnt : cnt_inc;
            valid      <= 1'b1;
`ifdef PERIOD_METER_CONTINUOUS_EN
            cnt        <= CNT_ZERO;
            fall_seen  <= 1'b0;
`else
            state      <= DONE;
            busy       <= 1'b0;
`endif
          end else if (cnt_at_limit) begin
            state   <= IDLE;
            timeout <= 1'b1;
            busy    <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (fall && !fall_seen) begin
              fall_seen <= 1'b1;
              high_cnt  <= cnt_inc;
            end
          end
        end

        DONE: begin
          // start takes priority over ack so a consumer can chain measurements
          if (start) begin
            state   <= ARM;
            cnt     <= CNT_ZERO;
            timeout <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b1;
          end else if (ack) begin
            state <= IDLE;
            valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// ---------------
// Randomized scoreboard bench for period_meter. A waveform generator drives
// sig_in as a square wave of chosen period/high time (or a held level); the
// expected result of each measurement is simply the waveform's own period and
// high time, pushed into a queue when the measurement is requested. A
// monitor pops and compares whenever valid or timeout rises.

module tb_period_meter;

  localparam int unsigned CW = 28;

  logic          clock_in = 1'b0;
  logic          reset_n;
  logic          sig_in;
  logic          start;
  logic          ack;
  logic          busy;
  logic          valid;
  logic          timeout;
  logic [CW-1:0] period_out;
  logic [CW-1:0] high_out;

  period_meter #(
    .CNT_WIDTH (CW),
    .TIMEOUT   (28'd100)
  ) dut (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .sig_in     (sig_in),
    .start      (start),
    .ack        (ack),
    .busy       (busy),
    .valid      (valid),
    .timeout    (timeout),
    .period_out (period_out),
    .high_out   (high_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    bit          is_to;
    int unsigned per;
    int unsigned hi;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned last_per = 0;
  int unsigned last_hi  = 0;

  // waveform control
  bit          gen_en     = 1'b0;
  bit          hold_level = 1'b0;
  int unsigned wave_p     = 10;
  int unsigned wave_h     = 5;
  int unsigned gen_p;
  int unsigned gen_h;

  // monitor bookkeeping
  logic        prev_valid = 1'b0;
  logic        prev_to    = 1'b0;
  int          valid_count = 0;
  longint      cycle = 0;
  longint      last_valid_cycle = -1;

  // stimulus scratch
  int          n;
  int          errs;
  int          vc_snap;
  bit          vseen;
  int unsigned rp;
  int unsigned rh;

  always @(posedge clock_in) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive start/ack for exactly one cycle; returns just after the edge that
  // registered them.
  task automatic applyStimulus(input bit s, input bit a);
    @(posedge clock_in); #1;
    start = s;
    ack   = a;
    @(posedge clock_in); #1;
    start = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic waitValid(input int limit, input string name);
    int k = 0;
    while (!valid && k < limit) begin
      @(negedge clock_in);
      k++;
    end
    checkOutput(name, 32'(valid), 32'd1);
  endtask

  task automatic waitTimeout(input int limit, input string name);
    int k = 0;
    while (!timeout && k < limit) begin
      @(posedge clock_in); #1;
      k++;
    end
    checkOutput(name, 32'(timeout), 32'd1);
  endtask

  // Switch the generator to a new wave, let it settle, then request a
  // measurement whose expected answer is the wave itself.
  task automatic measureWave(input int unsigned p, input int unsigned h,
                             input string name);
    exp_t e;
    wave_p = p;
    wave_h = h;
    gen_en = 1'b1;
    repeat (75) @(posedge clock_in);
    #1;
    e.is_to = 1'b0;
    e.per   = p;
    e.hi    = h;
    sb.push_back(e);
    last_per = p;
    last_hi  = h;
    applyStimulus(1'b1, 1'b0);
    waitValid(2 * int'(p) + 3, name);
  endtask

  task automatic pushTimeout();
    exp_t e;
    e.is_to = 1'b1;
    e.per   = last_per;
    e.hi    = last_hi;
    sb.push_back(e);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},    32'(busy),       32'd0);
    checkOutput({tag, "_valid"},   32'(valid),      32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout),    32'd0);
    checkOutput({tag, "_period"},  32'(period_out), 32'd0);
    checkOutput({tag, "_high"},    32'(high_out),   32'd0);
  endtask

  // Square-wave generator: parameters are latched at the start of each
  // period, so a wave change never produces a torn period.
  initial begin
    sig_in = 1'b0;
    forever begin
      if (gen_en) begin
        gen_p = wave_p;
        gen_h = wave_h;
        sig_in = 1'b1;
        repeat (gen_h) begin @(posedge clock_in); #1; end
        sig_in = 1'b0;
        repeat (gen_p - gen_h) begin @(posedge clock_in); #1; end
      end else begin
        sig_in = hold_level;
        @(posedge clock_in); #1;
      end
    end
  end

  // Monitor: compares against the scoreboard on every rising valid/timeout.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock_in);
      if (reset_n === 1'b1) begin
        if (valid && !prev_valid) begin
          valid_count++;
`ifdef PERIOD_METER_CONTINUOUS_EN
          if (last_valid_cycle >= 0)
            checkOutput("pulse_spacing", 32'(cycle - last_valid_cycle), 32'(wave_p));
          last_valid_cycle = cycle;
`endif
          if (sb.size() == 0) begin
            checkOutput("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_kind_valid", 32'(e.is_to), 32'd0);
            checkOutput("period_out", 32'(period_out), e.per);
            checkOutput("high_out", 32'(high_out), e.hi);
            checkOutput("timeout_at_valid", 32'(timeout), 32'd0);
`ifdef PERIOD_METER_CONTINUOUS_EN
            checkOutput("busy_at_valid", 32'(busy), 32'd1);
`else
            checkOutput("busy_at_valid", 32'(busy), 32'd0);
`endif
          end
        end
`ifdef PERIOD_METER_CONTINUOUS_EN
        if (valid && prev_valid)
          checkOutput("valid_one_cycle", 32'd1, 32'd0);
`endif
        if (timeout && !prev_to) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_timeout", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            checkOutput("sb_kind_timeout", 32'(e.is_to), 32'd1);
            checkOutput("period_kept", 32'(period_out), e.per);
            checkOutput("high_kept", 32'(high_out), e.hi);
            checkOutput("busy_at_timeout", 32'(busy), 32'd0);
            checkOutput("valid_at_timeout", 32'(valid), 32'd0);
          end
        end
      end
      prev_valid = valid;
      prev_to    = timeout;
    end
  end

  // Stimulus
  initial begin
    $display("[TB] period_meter bench starting");
    reset_n = 1'b0;
    start   = 1'b0;
    ack     = 1'b0;
    repeat (3) @(posedge clock_in);
    #1;
    checkResetOutputs("rst");
    reset_n = 1'b1;

`ifdef PERIOD_METER_CONTINUOUS_EN
    // Continuous mode: one start, periodic one-cycle valid pulses; ack held
    // high throughout must have no effect.
    wave_p = 10;
    wave_h = 5;
    gen_en = 1'b1;
    repeat (75) @(posedge clock_in);
    #1;
    last_per = 10;
    last_hi  = 5;
    sb.push_back('{is_to: 1'b0, per: 10, hi: 5});
    applyStimulus(1'b1, 1'b0);
    ack = 1'b1;
    checkOutput("cont_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      vc_snap = valid_count;
      n = 0;
      while (valid_count == vc_snap && n < 60) begin
        @(negedge clock_in);
        n++;
      end
      checkOutput("cont_pulse", 32'(valid_count - vc_snap), 32'd1);
      if (i < 4) sb.push_back('{is_to: 1'b0, per: 10, hi: 5});
    end
    gen_en = 1'b0;
    hold_level = 1'b0;
    pushTimeout();
    waitTimeout(300, "cont_timeout");
    ack = 1'b0;
`else
    // Divided clock, 10 cycles with 5 high.
    measureWave(10, 5, "valid_p10");
    errs = 0;
    repeat (40) begin
      @(negedge clock_in);
      if (!valid || period_out != 28'd10 || high_out != 28'd5 || busy) errs++;
    end
    checkOutput("hold_stable", 32'(errs), 32'd0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ack_valid_drop", 32'(valid), 32'd0);
    checkOutput("ack_busy", 32'(busy), 32'd0);

    // Stuck-low input: abort exactly TIMEOUT cycles after start registers.
    gen_en = 1'b0;
    hold_level = 1'b0;
    repeat (20) @(posedge clock_in);
    #1;
    pushTimeout();
    applyStimulus(1'b1, 1'b0);
    checkOutput("busy_arm", 32'(busy), 32'd1);
    n = 0;
    vseen = 1'b0;
    while (!timeout && n < 300) begin
      @(posedge clock_in); #1;
      n++;
      if (valid) vseen = 1'b1;
    end
    checkOutput("timeout_cycles", 32'(n), 32'd100);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    checkOutput("timeout_no_valid", 32'(vseen), 32'd0);

    // 25% duty, then start+ack together in DONE chains a new measurement.
    measureWave(16, 4, "valid_p16");
    sb.push_back('{is_to: 1'b0, per: 16, hi: 4});
    applyStimulus(1'b1, 1'b1);
    checkOutput("chain_valid_drop", 32'(valid), 32'd0);
    checkOutput("chain_busy", 32'(busy), 32'd1);
    waitValid(2 * 16 + 3, "valid_chain");
    applyStimulus(1'b0, 1'b1);

    // Rise, fall, then no further rise: abort in MEASURE must keep 16/4.
    gen_en = 1'b0;
    hold_level = 1'b0;
    repeat (40) @(posedge clock_in);
    #1;
    pushTimeout();
    applyStimulus(1'b1, 1'b0);
    repeat (5) @(posedge clock_in);
    hold_level = 1'b1;
    repeat (10) @(posedge clock_in);
    hold_level = 1'b0;
    waitTimeout(300, "measure_timeout");

    // Reset in the middle of a measurement.
    repeat (10) @(posedge clock_in);
    #1;
    applyStimulus(1'b1, 1'b0);
    repeat (5) @(posedge clock_in);
    hold_level = 1'b1;
    repeat (10) @(posedge clock_in);
    #1;
    checkOutput("busy_measure", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    sb.delete();
    last_per = 0;
    last_hi  = 0;
    @(posedge clock_in); #1;
    reset_n = 1'b1;
    hold_level = 1'b0;
    measureWave(12, 6, "valid_after_reset");
    applyStimulus(1'b0, 1'b1);

    // Random waves.
    for (int i = 0; i < 8; i++) begin
      rp = $urandom_range(60, 4);
      rh = $urandom_range(rp - 1, 1);
      measureWave(rp, rh, "valid_random");
      repeat ($urandom_range(5, 0)) @(posedge clock_in);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rand_ack_valid", 32'(valid), 32'd0);
    end
`endif

    repeat (5) @(posedge clock_in);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures a slow square wave, such as the output of the project clock divider, against the system clock `clock_in`.
- Reports two values in `clock_in` cycles: the period (rising edge to rising edge) and the high time (rising edge to falling edge).
- Works as the receive side of the divided-clock path: it checks divider ratio and duty cycle on the board and exposes them to the datapath/display logic.
- Single-shot measurement with a valid/ack handshake and a timeout for stuck inputs.

Parameters:
- CNT_WIDTH, 28, width of the cycle counter and of both result ports.
- TIMEOUT, 28'd50000000, cycles without a required edge before the measurement aborts; must be >= 2 and <= 2^CNT_WIDTH-1.

Ports:
- clock_in  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- sig_in  in  1  signal to measure; asynchronous to `clock_in`.
- start  in  1  one-cycle request to begin a measurement.
- ack  in  1  consumer acknowledges the result.
- busy  out  1  high in ARM or MEASURE.
- valid  out  1  result available (DONE state).
- timeout  out  1  sticky: last measurement aborted.
- period_out  out  CNT_WIDTH  measured period in cycles.
- high_out  out  CNT_WIDTH  measured high time in cycles.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; cnt=0.
  - Synchronizer flops = 0.
  - busy=0, valid=0, timeout=0, period_out=0, high_out=0.
- Input path:
  - 2-flop synchronizer s1->s2, then an edge register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Latency from a sig_in transition to the rise/fall pulse: 2-3 cycles.
  - The latency is identical for all edges, so measured intervals are exact to ±1 cycle of input jitter.
- IDLE:
  - start=1 -> ARM, cnt<=0, timeout<=0.
  - ack is ignored.
- ARM (waiting for the first rising edge):
  - rise -> MEASURE, cnt<=0.
  - Else cnt increments. If cnt==TIMEOUT-1 -> IDLE with timeout<=1.
- MEASURE:
  - cnt increments every cycle.
  - On the first fall: high_out<=cnt+1. Later falls in the same measurement are ignored.
  - On rise: period_out<=cnt+1, then -> DONE.
  - If rise arrives with no fall seen: high_out<=period_out value, i.e. reported as 100% high. This cannot occur with a clean square wave.
  - If cnt==TIMEOUT-1 with no rise -> IDLE, timeout<=1; period_out/high_out keep their previous values.
- DONE:
  - valid=1; outputs held stable.
  - ack -> IDLE, valid drops the next cycle.
  - start -> ARM with valid dropping. Start wins over a simultaneous ack.
- start while busy is ignored. Edges seen in IDLE/DONE are ignored.
- Arithmetic:
  - cnt+1 is computed at CNT_WIDTH bits. TIMEOUT bounds cnt, so it never wraps.
  - Example: a rise at detected cycle t and the next at t+P gives period_out=P.
- Reset asserted mid-measurement: immediate return to the reset values; no partial result is retained.

Optional Feature:
- Macro: PERIOD_METER_CONTINUOUS_EN.
- Defined:
  - After the first result, the terminating rise also starts the next measurement: MEASURE -> MEASURE with cnt<=0.
  - valid pulses high for exactly one cycle per completed period; period_out/high_out update every period.
  - ack is ignored.
  - Only a start pulse while in IDLE begins operation; timeout returns to IDLE as usual.
  - busy stays high while running.
- Not defined: single-shot behaviour as above; the DONE state exists and holds until ack or start.

Test Plan:
- sig_in = divided clock, 10 cycles per period, 5 high; pulse start -> valid within 2 periods + 3 cycles; period_out=10, high_out=5; busy low once valid rises.
- Same run, hold ack=0 for 40 cycles -> valid and outputs stay stable; ack=1 -> valid=0 next cycle, state IDLE.
- TIMEOUT=100, sig_in held 0, start -> timeout=1 and busy=0 exactly 100 cycles after start registers; valid stays 0.
- 25%-duty input, period 16 (4 high), start and ack asserted together while in DONE -> new measurement begins; valid drops, then re-asserts with period_out=16, high_out=4.
- reset_n pulsed low mid-MEASURE -> all outputs 0 immediately; the next start measures correctly.
- With PERIOD_METER_CONTINUOUS_EN, period-10 input, one start -> one-cycle valid pulses spaced 10 cycles apart, each with period_out=10 and high_out=5.
